crc_stream_engine: RTL and testbench

Parametrised streaming CRC engine, successor to the MKW2xD CRC register block. It computes CRC-8/16/24/32 over a valid/ready word stream using any generator polynomial. Processing runs at a configurable number of bits per clock, and the last word may be partial. Sits behind a bus-register front end or a DMA streamer, which supplies configuration and consumes `crc_out`/`crc_valid`.

---
 rtl/crc_stream_engine_if.sv | 35 +++
 rtl/crc_stream_engine.sv | 134 +++++++++++++
 tb/tb_crc_stream_engine.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_stream_engine_if.sv
// Configuration, input handshake and result bundle for crc_stream_engine.
// The master side drives config and data; the engine is the slave.
interface crc_stream_engine_if #(
  parameter int unsigned CRC_W  = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned LEN_W = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1;

  logic [CRC_W-1:0]  cfg_poly;
  logic [CRC_W-1:0]  cfg_seed;
  logic [1:0]        cfg_tot;
  logic [1:0]        cfg_totr;
  logic              cfg_fxor;
  logic              seed_load;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [LEN_W-1:0]  in_len;
  logic              in_last;
  logic              busy;
  logic              crc_valid;
  logic [CRC_W-1:0]  crc_out;

  modport master (
    output cfg_poly, cfg_seed, cfg_tot, cfg_totr, cfg_fxor, seed_load,
           in_valid, in_data, in_len, in_last,
    input  in_ready, busy, crc_valid, crc_out
  );

  modport slave (
    input  cfg_poly, cfg_seed, cfg_tot, cfg_totr, cfg_fxor, seed_load,
           in_valid, in_data, in_len, in_last,
    output in_ready, busy, crc_valid, crc_out
  );
endinterface

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: arbitrary polynomial, BPC bits per clock, MSB-first,
// with write/read transposes and a final complement option.
module crc_stream_engine #(
  parameter int unsigned CRC_W  = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BPC    = 8
) (
  input  logic               clk,
  input  logic               rst,
  crc_stream_engine_if.slave bus
);
  localparam int unsigned NBYTES     = DATA_W / 8;
  localparam int unsigned LEN_W      = (DATA_W > 8) ? $clog2(NBYTES) : 1;
  localparam int unsigned MAX_S      = DATA_W / BPC;
  localparam int unsigned CNT_W      = $clog2(MAX_S + 1);
  localparam bit          NEED_CLAMP = (2 ** LEN_W) > NBYTES;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t            r_state;
  logic [CRC_W-1:0]  r_crc;
  logic [CRC_W-1:0]  r_poly;
  logic [CRC_W-1:0]  r_crc_out;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last;
  logic              r_crc_valid;

  logic [LEN_W-1:0]  w_len;
  logic [CNT_W-1:0]  w_steps;
  logic [CRC_W-1:0]  w_crc_nxt;
  logic [CRC_W-1:0]  w_result;

  // Transpose modes: 00 none, 01 bit-reverse per byte, 10 full reverse, 11 byte swap.
  function automatic logic [DATA_W-1:0] xpose_data(input logic [DATA_W-1:0] v,
                                                   input logic [1:0] m);
    logic [DATA_W-1:0] r;
    r = v;
    case (m)
      2'b01:   for (int i = 0; i < DATA_W; i++) r[i] = v[(i / 8) * 8 + 7 - (i % 8)];
      2'b10:   for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W - 1 - i];
      2'b11:   for (int b = 0; b < DATA_W / 8; b++) r[b*8 +: 8] = v[(DATA_W/8 - 1 - b)*8 +: 8];
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic [CRC_W-1:0] xpose_crc(input logic [CRC_W-1:0] v,
                                                 input logic [1:0] m);
    logic [CRC_W-1:0] r;
    r = v;
    case (m)
      2'b01:   for (int i = 0; i < CRC_W; i++) r[i] = v[(i / 8) * 8 + 7 - (i % 8)];
      2'b10:   for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W - 1 - i];
      2'b11:   for (int b = 0; b < CRC_W / 8; b++) r[b*8 +: 8] = v[(CRC_W/8 - 1 - b)*8 +: 8];
      default: r = v;
    endcase
    return r;
  endfunction

  // Oversized byte counts saturate to a full word.
  if (NEED_CLAMP) begin : g_clamp
    assign w_len = (bus.in_len > LEN_W'(NBYTES - 1)) ? LEN_W'(NBYTES - 1) : bus.in_len;
  end else begin : g_noclamp
    assign w_len = bus.in_len;
  end

  assign w_steps = CNT_W'(((32'(w_len) + 32'd1) * 32'd8) / BPC);

  // BPC unrolled serial LFSR steps fed from the top of the shift register.
  always_comb begin
    w_crc_nxt = r_crc;
    for (int i = 0; i < BPC; i++) begin
      if (w_crc_nxt[CRC_W-1] ^ r_shift[DATA_W-1-i])
        w_crc_nxt = {w_crc_nxt[CRC_W-2:0], 1'b0} ^ r_poly;
      else
        w_crc_nxt = {w_crc_nxt[CRC_W-2:0], 1'b0};
    end
  end

  assign w_result = xpose_crc(w_crc_nxt, bus.cfg_totr) ^ {CRC_W{bus.cfg_fxor}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_crc       <= '1;
      r_poly      <= '0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_last      <= 1'b0;
      r_crc_out   <= '0;
      r_crc_valid <= 1'b0;
    end else begin
      r_crc_valid <= 1'b0;
      if (bus.seed_load) begin
        // Reseed aborts any word in flight and blocks a same-cycle transfer.
        r_crc   <= bus.cfg_seed;
        r_cnt   <= '0;
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.in_valid) begin
              r_shift <= xpose_data(bus.in_data, bus.cfg_tot);
              r_poly  <= bus.cfg_poly;
              r_last  <= bus.in_last;
              r_cnt   <= w_steps;
              r_state <= ST_BUSY;
            end
          end
          ST_BUSY: begin
            r_crc   <= w_crc_nxt;
            r_shift <= r_shift << BPC;
            r_cnt   <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state <= ST_IDLE;
              if (r_last) begin
                r_crc_out   <= w_result;
                r_crc_valid <= 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready  = ~rst & (r_state == ST_IDLE) & ~bus.seed_load;
  assign bus.busy      = (r_state == ST_BUSY);
  assign bus.crc_valid = r_crc_valid;
  assign bus.crc_out   = r_crc_out;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: three configurations (CRC-16/BPC 8, CRC-32/BPC 8,
// CRC-32/BPC 1) checked against a polynomial-division reference model.
module tb_crc_stream_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] d_poly, d_seed, d_data;
  logic [1:0]  d_tot, d_totr, d_len;
  logic        d_fxor, d_seed_load, d_valid, d_last;
  int          sel;

  int n_vec  = 0;
  int n_err  = 0;
  int n_crcv = 0;

  logic [31:0] m_init;
  logic [7:0]  q_msg[$];

  logic        o_ready, o_busy, o_valid;
  logic [31:0] o_crc;

  crc_stream_engine_if #(.CRC_W(16), .DATA_W(32)) if16 ();
  crc_stream_engine_if #(.CRC_W(32), .DATA_W(32)) if32 ();
  crc_stream_engine_if #(.CRC_W(32), .DATA_W(32)) if32s ();

  assign if16.cfg_poly = d_poly[15:0];  assign if16.cfg_seed = d_seed[15:0];
  assign if16.cfg_tot  = d_tot;         assign if16.cfg_totr = d_totr;
  assign if16.cfg_fxor = d_fxor;        assign if16.in_data  = d_data;
  assign if16.in_len   = d_len;         assign if16.in_last  = d_last;
  assign if16.in_valid  = d_valid && (sel == 0);
  assign if16.seed_load = d_seed_load && (sel == 0);

  assign if32.cfg_poly = d_poly;        assign if32.cfg_seed = d_seed;
  assign if32.cfg_tot  = d_tot;         assign if32.cfg_totr = d_totr;
  assign if32.cfg_fxor = d_fxor;        assign if32.in_data  = d_data;
  assign if32.in_len   = d_len;         assign if32.in_last  = d_last;
  assign if32.in_valid  = d_valid && (sel == 1);
  assign if32.seed_load = d_seed_load && (sel == 1);

  assign if32s.cfg_poly = d_poly;       assign if32s.cfg_seed = d_seed;
  assign if32s.cfg_tot  = d_tot;        assign if32s.cfg_totr = d_totr;
  assign if32s.cfg_fxor = d_fxor;       assign if32s.in_data  = d_data;
  assign if32s.in_len   = d_len;        assign if32s.in_last  = d_last;
  assign if32s.in_valid  = d_valid && (sel == 2);
  assign if32s.seed_load = d_seed_load && (sel == 2);

  crc_stream_engine #(.CRC_W(16), .DATA_W(32), .BPC(8)) u_crc16 (
    .clk(clk), .rst(rst), .bus(if16.slave));
  crc_stream_engine #(.CRC_W(32), .DATA_W(32), .BPC(8)) u_crc32 (
    .clk(clk), .rst(rst), .bus(if32.slave));
  crc_stream_engine #(.CRC_W(32), .DATA_W(32), .BPC(1)) u_crc32_s (
    .clk(clk), .rst(rst), .bus(if32s.slave));

  always_comb begin
    case (sel)
      0: begin
        o_ready = if16.in_ready; o_busy = if16.busy;
        o_valid = if16.crc_valid; o_crc = {16'h0, if16.crc_out};
      end
      1: begin
        o_ready = if32.in_ready; o_busy = if32.busy;
        o_valid = if32.crc_valid; o_crc = if32.crc_out;
      end
      default: begin
        o_ready = if32s.in_ready; o_busy = if32s.busy;
        o_valid = if32s.crc_valid; o_crc = if32s.crc_out;
      end
    endcase
  end

  // busy and in_ready must never be high together on any instance.
  always @(negedge clk) begin
    n_vec++;
    assert (!(if16.busy && if16.in_ready) && !(if32.busy && if32.in_ready) &&
            !(if32s.busy && if32s.in_ready))
    else begin
      n_err++;
      $error("FAIL busy_ready_excl: observed %b%b %b%b %b%b expected no pair 11",
             if16.busy, if16.in_ready, if32.busy, if32.in_ready, if32s.busy, if32s.in_ready);
    end
    if (o_valid) n_crcv++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int w_of(input int s);
    return (s == 0) ? 16 : 32;
  endfunction

  function automatic int bpc_of(input int s);
    return (s == 2) ? 1 : 8;
  endfunction

  function automatic logic [31:0] mask_of(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Transpose of a w-bit value held in the low bits, built from streaming operators.
  function automatic logic [31:0] tx(input logic [31:0] v, input logic [1:0] m, input int w);
    logic [31:0] bitrev, byterev, inbyte;
    bitrev  = {<<{v}};
    byterev = {<<8{v}};
    inbyte  = {<<8{bitrev}};
    case (m)
      2'b01:   return inbyte;
      2'b10:   return bitrev >> (32 - w);
      2'b11:   return byterev >> (32 - w);
      default: return v;
    endcase
  endfunction

  // Non-augmented CRC = (init * x^n + msg * x^w) mod (x^w + poly), by long division.
  function automatic logic [31:0] ref_crc(input logic [7:0] msg[$], input int w,
                                          input logic [31:0] poly, input logic [31:0] init,
                                          input logic [1:0] totr, input logic fxor);
    bit          b[$];
    int          n;
    logic [31:0] rem;
    foreach (msg[i]) for (int k = 7; k >= 0; k--) b.push_back(msg[i][k]);
    n = b.size();
    for (int j = 0; j < w; j++) b.push_back(1'b0);
    for (int j = 0; j < w; j++) b[j] ^= init[w-1-j];
    for (int i = 0; i < n; i++) begin
      if (b[i]) begin
        b[i] = 1'b0;
        for (int k = 0; k < w; k++) b[i+1+k] ^= poly[w-1-k];
      end
    end
    rem = '0;
    for (int k = 0; k < w; k++) rem[w-1-k] = b[n+k];
    rem = tx(rem, totr, w);
    if (fxor) rem ^= mask_of(w);
    return rem;
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic do_seed();
    d_seed_load = 1'b1;
    @(posedge clk);
    #1 d_seed_load = 1'b0;
    m_init = d_seed & mask_of(w_of(sel));
    q_msg.delete();
    @(negedge clk);
  endtask

  // Called at a negedge; transfers one word and checks latency and any result.
  task automatic send_word(input logic [31:0] data, input logic [1:0] len,
                           input logic last, input string tag);
    int          n, steps;
    logic [31:0] x, exp;
    steps = (8 * (int'(len) + 1)) / bpc_of(sel);
    x = tx(data, d_tot, 32);
    for (int b = 0; b <= int'(len); b++) q_msg.push_back(x[31-8*b -: 8]);
    d_data = data; d_len = len; d_last = last; d_valid = 1'b1;
    #1 chk({tag, "/ready_in"}, 32'(o_ready), 32'd1);
    @(posedge clk);
    #1 d_valid = 1'b0; d_last = 1'b0;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (o_busy) n++;
      else break;
    end
    chk({tag, "/busy_cycles"}, 32'(n), 32'(steps));
    chk({tag, "/ready_out"}, 32'(o_ready), 32'd1);
    if (last) begin
      exp = ref_crc(q_msg, w_of(sel), d_poly & mask_of(w_of(sel)), m_init, d_totr, d_fxor);
      q_msg.delete();
      chk({tag, "/valid"}, 32'(o_valid), 32'd1);
      chk({tag, "/crc"}, o_crc, exp);
      @(negedge clk);
      chk({tag, "/valid_pulse"}, 32'(o_valid), 32'd0);
    end else begin
      chk({tag, "/no_valid"}, 32'(o_valid), 32'd0);
    end
  endtask

  task automatic send_check(input string tag);
    send_word(32'h3132_3334, 2'd3, 1'b0, tag);
    send_word(32'h3536_3738, 2'd3, 1'b0, tag);
    send_word(32'h3900_0000, 2'd0, 1'b1, tag);
  endtask

  task automatic cfg_crc16();
    d_poly = 32'h0000_1021; d_seed = 32'h0000_FFFF;
    d_tot = 2'b00; d_totr = 2'b00; d_fxor = 1'b0;
  endtask

  task automatic cfg_crc32();
    d_poly = 32'h04C1_1DB7; d_seed = 32'hFFFF_FFFF;
    d_tot = 2'b01; d_totr = 2'b10; d_fxor = 1'b1;
  endtask

  initial begin
    int vc, nw;
    rst = 1'b1; sel = 0;
    d_poly = '0; d_seed = '0; d_data = '0; d_tot = '0; d_totr = '0; d_len = '0;
    d_fxor = 1'b0; d_seed_load = 1'b0; d_valid = 1'b0; d_last = 1'b0;
    m_init = '0;

    repeat (2) @(negedge clk);
    chk("rst/ready", 32'(o_ready), 32'd0);
    chk("rst/busy", 32'(o_busy), 32'd0);
    chk("rst/valid", 32'(o_valid), 32'd0);
    chk("rst/crc_out", o_crc, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst/ready", 32'(o_ready), 32'd1);

    // CRC-16/CCITT-FALSE straight out of reset: reset value equals seed 0xFFFF.
    cfg_crc16(); m_init = 32'h0000_FFFF; q_msg.delete();
    send_check("ccitt_noseed");
    chk("ccitt_noseed/const", o_crc, 32'h0000_29B1);
    do_seed();
    send_check("ccitt");
    chk("ccitt/const", o_crc, 32'h0000_29B1);

    sel = 1; cfg_crc32(); @(negedge clk);
    do_seed();
    send_check("crc32");
    chk("crc32/const", o_crc, 32'hCBF4_3926);

    sel = 2; @(negedge clk);
    do_seed();
    send_check("crc32_bpc1");
    chk("crc32_bpc1/const", o_crc, 32'hCBF4_3926);

    // Abort a word with seed_load in its second BUSY cycle.
    sel = 0; cfg_crc16(); @(negedge clk);
    do_seed();
    vc = n_crcv;
    d_data = 32'h3132_3334; d_len = 2'd3; d_last = 1'b1; d_valid = 1'b1;
    @(posedge clk);
    #1 d_valid = 1'b0; d_last = 1'b0;
    @(negedge clk);
    chk("abort/busy1", 32'(o_busy), 32'd1);
    @(negedge clk);
    d_seed_load = 1'b1;
    @(posedge clk);
    #1 d_seed_load = 1'b0;
    @(negedge clk);
    chk("abort/ready", 32'(o_ready), 32'd1);
    chk("abort/busy", 32'(o_busy), 32'd0);
    repeat (6) @(negedge clk);
    chk("abort/no_valid", 32'(n_crcv), 32'(vc));
    m_init = 32'h0000_FFFF; q_msg.delete();
    send_check("abort_restart");

    // seed_load together with in_valid in IDLE: no transfer.
    d_seed = 32'h0000_1D0F; d_seed_load = 1'b1; d_valid = 1'b1;
    d_data = 32'hA5A5_5A5A; d_len = 2'd3; d_last = 1'b1;
    #1 chk("seed_vs_valid/ready", 32'(o_ready), 32'd0);
    @(posedge clk);
    #1 d_seed_load = 1'b0; d_valid = 1'b0; d_last = 1'b0;
    m_init = 32'h0000_1D0F; q_msg.delete();
    @(negedge clk);
    chk("seed_vs_valid/busy", 32'(o_busy), 32'd0);
    send_word(32'hDEAD_BEEF, 2'd1, 1'b1, "seed_vs_valid/msg");

    // Randomised messages across all three engines.
    for (int m = 0; m < 12; m++) begin
      sel = int'($urandom_range(0, 2));
      d_poly = $urandom; d_seed = $urandom;
      d_tot = 2'($urandom); d_totr = 2'($urandom); d_fxor = 1'($urandom);
      @(negedge clk);
      do_seed();
      nw = int'($urandom_range(1, 3));
      for (int k = 0; k < nw; k++)
        send_word($urandom, 2'($urandom), (k == nw - 1), $sformatf("rand%0d", m));
    end

    // Reset in the middle of a word: reset values next cycle, no result.
    sel = 1; cfg_crc32(); @(negedge clk);
    do_seed();
    send_word(32'h0123_4567, 2'd3, 1'b1, "pre_rst");
    vc = n_crcv;
    d_data = 32'h3132_3334; d_len = 2'd3; d_last = 1'b1; d_valid = 1'b1;
    @(posedge clk);
    #1 d_valid = 1'b0; d_last = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst/busy", 32'(o_busy), 32'd0);
    chk("mid_rst/valid", 32'(o_valid), 32'd0);
    chk("mid_rst/crc_out", o_crc, 32'd0);
    chk("mid_rst/ready", 32'(o_ready), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_rst/no_valid", 32'(n_crcv), 32'(vc));
    m_init = 32'hFFFF_FFFF; q_msg.delete();
    send_check("post_rst_crc32");
    chk("post_rst_crc32/const", o_crc, 32'hCBF4_3926);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
